// File: rtl/psram_arb_pkg.sv
// Shared types and widths for the PSRAM port arbiter.
// Imported by the picker and the arbiter top.
package psram_arb_pkg;

  localparam int NPORT = 3;
  localparam int AW    = 22;
  localparam int DW    = 32;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_ISSUE  = 3'd1,
    ARB_SETTLE = 3'd2,
    ARB_WAIT   = 3'd3,
    ARB_DONE   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Searches from last+1 modulo 3.
module rr_pick3
  import psram_arb_pkg::*;
(
  input  logic [NPORT-1:0] req_i,
  input  logic [1:0]       last_i,
  output logic [1:0]       grant_o,
  output logic             valid_o
);

  always_comb begin
    grant_o = 2'd0;
    valid_o = |req_i;
    case (last_i)
      2'd0: begin
        if (req_i[1])      grant_o = 2'd1;
        else if (req_i[2]) grant_o = 2'd2;
        else               grant_o = 2'd0;
      end
      2'd1: begin
        if (req_i[2])      grant_o = 2'd2;
        else if (req_i[0]) grant_o = 2'd0;
        else               grant_o = 2'd1;
      end
      default: begin
        if (req_i[0])      grant_o = 2'd0;
        else if (req_i[1]) grant_o = 2'd1;
        else               grant_o = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/psram_arbiter.sv
// Three-port round-robin arbiter in front of the PSRAM word port.
// One rd/we pulse per access, then waits for ready with a watchdog.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int TIMEOUT = 4095,
  parameter int CNT_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORT-1:0]  req,
  input  logic [NPORT-1:0]  we_i,
  input  logic [AW-1:0]     a0_i,
  input  logic [AW-1:0]     a1_i,
  input  logic [AW-1:0]     a2_i,
  input  logic [DW-1:0]     d0_i,
  input  logic [DW-1:0]     d1_i,
  input  logic [DW-1:0]     d2_i,
  output logic [NPORT-1:0]  ack,
  output logic [DW-1:0]     rdata,
  output logic              err,
  output logic              busy,
  output logic [AW-1:0]     mem_a,
  output logic [DW-1:0]     mem_d,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic [DW-1:0]     mem_spo,
  input  logic              mem_ready
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       grant_q, grant_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    a_q, a_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic [1:0]       pick;
  logic             pick_v;
  logic             sel_we;
  logic [AW-1:0]    sel_a;
  logic [DW-1:0]    sel_d;

  rr_pick3 u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (pick),
    .valid_o (pick_v)
  );

  always_comb begin
    sel_we = we_i[0];
    sel_a  = a0_i;
    sel_d  = d0_i;
    case (pick)
      2'd1: begin
        sel_we = we_i[1];
        sel_a  = a1_i;
        sel_d  = d1_i;
      end
      2'd2: begin
        sel_we = we_i[2];
        sel_a  = a2_i;
        sel_d  = d2_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    a_d     = a_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_v) begin
          grant_d = pick;
          last_d  = pick;
          wr_d    = sel_we;
          a_d     = sel_a;
          dat_d   = sel_d;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_d = ARB_SETTLE;
      // controller ready is registered and still high here
      ARB_SETTLE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ready) begin
          state_d = ARB_DONE;
          if (!wr_q) rdata_d = mem_spo;
        end else if (TIMEOUT != 0 && cnt_d == TO_CNT) begin
          state_d = ARB_DONE;
          abort_d = 1'b1;
          if (!wr_q) rdata_d = '0;
        end
      end
      ARB_DONE: begin
        abort_d = 1'b0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= 2'd2;
      grant_q <= 2'd0;
      wr_q    <= 1'b0;
      a_q     <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      a_q     <= a_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_rd = (state_q == ARB_ISSUE) & ~wr_q;
  assign mem_we = (state_q == ARB_ISSUE) & wr_q;
  assign mem_a  = a_q;
  assign mem_d  = dat_q;
  assign ack    = (state_q == ARB_DONE) ? (3'b001 << grant_q) : 3'b000;
  assign err    = (state_q == ARB_DONE) & abort_q;
  assign busy   = (state_q != ARB_IDLE);
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed scoreboard bench for psram_arbiter with a PSRAM
// controller model whose ready latency and hang are programmable.
module tb_psram_arbiter;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  we_i = '0;
  logic [21:0] a0_i = '0, a1_i = '0, a2_i = '0;
  logic [31:0] d0_i = '0, d1_i = '0, d2_i = '0;
  logic [2:0]  ack;
  logic [31:0] rdata;
  logic        err, busy;
  logic [21:0] mem_a;
  logic [31:0] mem_d;
  logic        mem_we, mem_rd;
  logic [31:0] mem_spo;
  logic        mem_ready;

  always #5 clk = ~clk;

  psram_arbiter #(.TIMEOUT(TO), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .req(req), .we_i(we_i),
    .a0_i(a0_i), .a1_i(a1_i), .a2_i(a2_i),
    .d0_i(d0_i), .d1_i(d1_i), .d2_i(d2_i),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
    .mem_rd(mem_rd), .mem_spo(mem_spo), .mem_ready(mem_ready)
  );

  // controller model
  int          lat  = 3;
  bit          hang = 1'b0;
  int          mcnt;
  logic [21:0] maddr;
  bit          wvalid = 1'b0;
  logic [21:0] wa;
  logic [31:0] wd;

  function automatic logic [31:0] pat(input logic [21:0] a);
    if (a == 22'h000010) return 32'hDEADBEEF;
    return {10'h2A5, a};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b1;
      mem_spo   <= '0;
      mcnt      <= 0;
      maddr     <= '0;
    end else if (mem_rd || mem_we) begin
      mem_ready <= 1'b0;
      mcnt      <= lat;
      maddr     <= mem_a;
      if (mem_we) begin
        wvalid <= 1'b1;
        wa     <= mem_a;
        wd     <= mem_d;
      end
    end else if (!mem_ready && !hang) begin
      if (mcnt <= 1) begin
        mem_ready <= 1'b1;
        mem_spo   <= (wvalid && maddr == wa) ? wd : pat(maddr);
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  typedef struct {
    logic [1:0]  port;
    logic        we;
    logic [21:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        iss_q[$];
  exp_t        ack_q[$];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          ack_cnt = 0;
  int          left[3] = '{0, 0, 0};
  int          iss_cyc[3] = '{0, 0, 0};
  bit          issued[3] = '{0, 0, 0};
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_tx(input logic [1:0] p, input logic w,
                           input logic [21:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input logic e,
                           input int l);
    exp_t x;
    x.port = p; x.we = w; x.a = a; x.d = d;
    x.rd = rd; x.err = e; x.lat = l;
    iss_q.push_back(x);
    ack_q.push_back(x);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      if (mem_rd || mem_we) begin
        chk("issue_expected", iss_q.size() > 0, 1);
        if (iss_q.size() > 0) begin
          e = iss_q.pop_front();
          chk("issue_rd", mem_rd, !e.we);
          chk("issue_we", mem_we, e.we);
          chk("issue_a", mem_a, e.a);
          if (e.we) chk("issue_d", mem_d, e.d);
          iss_cyc[e.port] = cyc;
          issued[e.port] = 1'b1;
        end
      end
      if (ack != 3'b000) begin
        ack_cnt++;
        chk("ack_expected", ack_q.size() > 0, 1);
        if (ack_q.size() > 0) begin
          e = ack_q.pop_front();
          chk("ack_port", ack, 3'b001 << e.port);
          chk("ack_after_issue", issued[e.port], 1);
          chk("ack_latency", cyc - iss_cyc[e.port], e.lat);
          chk("ack_err", err, e.err);
          chk("busy_at_ack", busy, 1);
          if (!e.we) begin
            chk("rdata", rdata, e.rd);
            last_rd = e.rd;
          end else begin
            chk("rdata_hold", rdata, last_rd);
          end
          issued[e.port] = 1'b0;
        end
        for (int p = 0; p < 3; p++) begin
          if (ack[p]) begin
            if (left[p] > 0) left[p]--;
            if (left[p] == 0) req[p] = 1'b0;
          end
        end
      end else if (err) begin
        chk("err_without_ack", err, 0);
      end
    end
  endtask

  task automatic run(input int n, input int budget);
    int target;
    int k;
    target = ack_cnt + n;
    k = 0;
    while (ack_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk("ack_budget", ack_cnt, target);
    repeat (4) tick();
  endtask

  initial begin
    // reset values
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_d", mem_d, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    tick();

    // single read on port 1, 20-cycle ready
    lat = 20;
    a1_i = 22'h000010;
    we_i = 3'b000;
    expect_tx(2'd1, 1'b0, 22'h000010, 32'h0, 32'hDEADBEEF, 1'b0, 22);
    left[1] = 1;
    req[1] = 1'b1;
    run(1, 200);
    a1_i = 22'h000000;

    // single write on port 2 to top of memory
    lat = 5;
    a2_i = 22'h3FFFFF;
    d2_i = 32'h12345678;
    we_i = 3'b100;
    expect_tx(2'd2, 1'b1, 22'h3FFFFF, 32'h12345678, 32'h0, 1'b0, 7);
    left[2] = 1;
    req[2] = 1'b1;
    run(1, 200);
    we_i = 3'b000;

    // read back the written word on port 0
    a0_i = 22'h3FFFFF;
    expect_tx(2'd0, 1'b0, 22'h3FFFFF, 32'h0, 32'h12345678, 1'b0, 7);
    left[0] = 1;
    req[0] = 1'b1;
    run(1, 200);

    // contention from reset: order 0,1,2,0,1,2
    rst = 1'b1;
    lat = 3;
    a0_i = 22'h000100;
    a1_i = 22'h000200;
    a2_i = 22'h000300;
    req = 3'b111;
    left = '{2, 2, 2};
    last_rd = '0;
    for (int r = 0; r < 2; r++) begin
      expect_tx(2'd0, 1'b0, 22'h000100, 32'h0, pat(22'h000100), 1'b0, 5);
      expect_tx(2'd1, 1'b0, 22'h000200, 32'h0, pat(22'h000200), 1'b0, 5);
      expect_tx(2'd2, 1'b0, 22'h000300, 32'h0, pat(22'h000300), 1'b0, 5);
    end
    tick();
    rst = 1'b0;
    run(6, 400);

    // fairness: port 0 continuous, port 2 joins once
    left[0] = 2;
    req[0] = 1'b1;
    expect_tx(2'd0, 1'b0, 22'h000100, 32'h0, pat(22'h000100), 1'b0, 5);
    expect_tx(2'd2, 1'b0, 22'h000300, 32'h0, pat(22'h000300), 1'b0, 5);
    expect_tx(2'd0, 1'b0, 22'h000100, 32'h0, pat(22'h000100), 1'b0, 5);
    repeat (3) tick();
    left[2] = 1;
    req[2] = 1'b1;
    run(3, 300);

    // watchdog abort, then a normal access
    hang = 1'b1;
    a1_i = 22'h000010;
    expect_tx(2'd1, 1'b0, 22'h000010, 32'h0, 32'h0, 1'b1, TO + 2);
    left[1] = 1;
    req[1] = 1'b1;
    run(1, 200);
    hang = 1'b0;
    expect_tx(2'd1, 1'b0, 22'h000010, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    left[1] = 1;
    req[1] = 1'b1;
    run(1, 200);

    // reset during WAIT
    lat = 20;
    expect_tx(2'd1, 1'b0, 22'h000010, 32'h0, 32'hDEADBEEF, 1'b0, 22);
    left[1] = 1;
    req[1] = 1'b1;
    repeat (7) tick();
    chk("busy_in_wait", busy, 1);
    rst = 1'b1;
    req = 3'b000;
    left = '{0, 0, 0};
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_rd", mem_rd, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_pending_issue", iss_q.size(), 0);
    ack_q.delete();
    issued = '{0, 0, 0};
    last_rd = '0;
    rst = 1'b0;
    lat = 3;
    a0_i = 22'h000100;
    expect_tx(2'd0, 1'b0, 22'h000100, 32'h0, pat(22'h000100), 1'b0, 5);
    expect_tx(2'd1, 1'b0, 22'h000010, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    left[0] = 1;
    left[1] = 1;
    req = 3'b011;
    run(2, 300);

    chk("issue_queue_drained", iss_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
